// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank:
// function-select encodings and parameter checks.
package register_bank_pkg;

  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_CLR  = 3'b011;
  localparam logic [2:0] FS_LDB  = 3'b100;
  localparam logic [2:0] FS_LDH  = 3'b101;
  localparam logic [2:0] FS_SHB  = 3'b110;
  localparam logic [2:0] FS_SXH  = 3'b111;

  function automatic bit width_ok(int w);
    return (w >= 16) && ((w % 8) == 0);
  endfunction

  function automatic bit depth_ok(int n);
    return n >= 2;
  endfunction

endpackage

// File: rtl/register_bank_cell.sv
// One bank register with its sticky wrap flag.
// All operations are evaluated from the cell's own current value.
module register_cell
  import register_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             E,
  input  logic [2:0]       FunSel,
  input  logic [WIDTH-1:0] In,
  output logic [WIDTH-1:0] Q,
  output logic             Wrap
);

  logic [WIDTH-1:0] q_nxt;
  logic             w_nxt;

  always_comb begin
    q_nxt = Q;
    w_nxt = 1'b0;
    unique case (FunSel)
      FS_DEC: begin
        q_nxt = Q - WIDTH'(1);
        w_nxt = Wrap | (Q == '0);
      end
      FS_INC: begin
        q_nxt = Q + WIDTH'(1);
        w_nxt = Wrap | (&Q);
      end
      FS_LOAD: q_nxt = In;
      FS_CLR:  q_nxt = '0;
      FS_LDB:  q_nxt = WIDTH'(In[7:0]);
      FS_LDH:  q_nxt = WIDTH'(In[15:0]);
      FS_SHB: begin
        q_nxt = {Q[WIDTH-9:0], In[7:0]};
        w_nxt = Wrap;
      end
      FS_SXH:  q_nxt = WIDTH'($signed(In[15:0]));
      default: begin
        q_nxt = Q;
        w_nxt = Wrap;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      Q    <= '0;
      Wrap <= 1'b0;
    end else if (E) begin
      Q    <= q_nxt;
      Wrap <= w_nxt;
    end
  end

endmodule

// File: rtl/register_bank.sv
// Bank of NUM_REGS registers sharing one op select and data
// input, with two combinational read ports.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REGS-1:0]         E,
  input  logic [2:0]                  FunSel,
  input  logic [WIDTH-1:0]            In,
  input  logic [$clog2(NUM_REGS)-1:0] OutASel,
  input  logic [$clog2(NUM_REGS)-1:0] OutBSel,
  output logic [WIDTH-1:0]            OutA,
  output logic [WIDTH-1:0]            OutB,
  output logic [NUM_REGS-1:0]         Wrap
);

  localparam int SEL_W = $clog2(NUM_REGS);
  localparam int DEPTH = 1 << SEL_W;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("register_bank: WIDTH must be >=16 and a multiple of 8");
  end
  if (!depth_ok(NUM_REGS)) begin : g_bad_depth
    $error("register_bank: NUM_REGS must be >=2");
  end

  // Unused select codes map to zero-filled slots.
  logic [WIDTH-1:0] rd [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (i < NUM_REGS) begin : g_cell
      register_cell #(
        .WIDTH (WIDTH)
      ) u_cell (
        .clock  (clock),
        .reset  (reset),
        .E      (E[i]),
        .FunSel (FunSel),
        .In     (In),
        .Q      (rd[i]),
        .Wrap   (Wrap[i])
      );
    end else begin : g_zero
      assign rd[i] = '0;
    end
  end

  assign OutA = rd[OutASel];
  assign OutB = rd[OutBSel];

endmodule
